// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_wr_arbiter.
// master: the requesters plus downstream FIFO; slave: the arbiter itself.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  locked;
    logic [OW-1:0]         owner;

    modport master (
        output req, req_data, req_lock, fifo_full,
        input  gnt, fifo_wr_en, fifo_wdata, locked, owner
    );

    modport slave (
        input  req, req_data, req_lock, fifo_full,
        output gnt, fifo_wr_en, fifo_wdata, locked, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// Grants are combinational (zero-latency write); a granted requester may
// keep ownership across beats via req_lock.
// Optional feature macro: FIFO_WR_ARB_LOCK_EN enables the ARB/LOCK ownership
// hold; without it req_lock is ignored and locked is constant 0.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input logic            clk,
    input logic            rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic {ARB, LOCK} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] gnt_c;
    logic [OW-1:0]   sel_c;
    logic            hit_c;
    logic [WIDTH-1:0] wdata_c;

    // Index k positions after base, wrapping modulo NREQ (NREQ need not be 2^n).
    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    // Grant selection: nothing during reset or full; owner only in LOCK;
    // otherwise first requester after the last owner.
    always_comb begin
        gnt_c = '0;
        sel_c = owner_q;
        hit_c = 1'b0;
        if (!rst && !bus.fifo_full) begin
            if (state_q == LOCK) begin
                if (bus.req[owner_q]) begin
                    gnt_c[owner_q] = 1'b1;
                    hit_c          = 1'b1;
                end
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!hit_c && bus.req[rr_idx(owner_q, k)]) begin
                        sel_c                       = rr_idx(owner_q, k);
                        gnt_c[rr_idx(owner_q, k)]   = 1'b1;
                        hit_c                       = 1'b1;
                    end
                end
            end
        end
    end

    // Write data mux: granted word, zero when idle.
    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) wdata_c = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Next state: only a real grant moves owner/state, so a full FIFO holds both.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (hit_c) begin
            owner_d = sel_c;
`ifdef FIFO_WR_ARB_LOCK_EN
            state_d = bus.req_lock[sel_c] ? LOCK : ARB;
`else
            state_d = ARB;
`endif
        end
    end

    // State/owner registers; reset makes requester 0 next in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= OW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef FIFO_WR_ARB_LOCK_EN
    assign bus.locked = (state_q == LOCK);
`else
    logic unused_req_lock;
    assign unused_req_lock = ^bus.req_lock;
    assign bus.locked      = 1'b0;
`endif

    assign bus.gnt        = gnt_c;
    assign bus.fifo_wr_en = hit_c;
    assign bus.fifo_wdata = wdata_c;
    assign bus.owner      = owner_q;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001: Parameter WIDTH, default 8, SHALL be the data width of each requester word and of the FIFO write port.
REQ-002: Parameter NREQ, default 4, SHALL be the number of requesters; legal range 2..8.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005: req  input  NREQ  SHALL carry per-requester write request; bit i means requester i has a word.
REQ-006: req_data  input  NREQ*WIDTH  SHALL carry requester i's word in bits [i*WIDTH +: WIDTH].
REQ-007: req_lock  input  NREQ  SHALL mean requester i wants to keep ownership after its current beat.
REQ-008: gnt  output  NREQ  SHALL be one-hot or zero; bit i means requester i's word is accepted this cycle.
REQ-009: fifo_full  input  1  SHALL be the full flag of the downstream FIFO.
REQ-010: fifo_wr_en  output  1  SHALL be the downstream FIFO write enable.
REQ-011: fifo_wdata  output  WIDTH  SHALL be the downstream FIFO write data.
REQ-012: locked  output  1  SHALL be high while the FSM is in LOCK.
REQ-013: owner  output  $clog2(NREQ)  SHALL be the index of the last granted requester.

Function
REQ-014: gnt, fifo_wr_en and fifo_wdata SHALL be combinational from the current inputs and registered state; grant-to-write latency is zero cycles.
REQ-015: fifo_wr_en SHALL equal OR of gnt; fifo_wdata SHALL be the granted requester's word, or all zeros when no grant.
REQ-016: No grant SHALL issue while fifo_full=1 or rst=1; the arbiter is the only writer of the FIFO.
REQ-017: FSM states SHALL be ARB and LOCK.
REQ-018: In ARB, the grant SHALL go to the first requester with req=1, searching round-robin from owner+1 and wrapping modulo NREQ.
REQ-019: On any grant, owner SHALL update to the granted index at the next edge.
REQ-020: ARB->LOCK SHALL occur on an edge where requester i is granted with req_lock[i]=1.
REQ-021: In LOCK, only requester owner SHALL be grantable; other requests SHALL wait even if the owner's req=0.
REQ-022: LOCK->ARB SHALL occur on an edge where owner is granted with req_lock[owner]=0, which marks the last beat.
REQ-023: When fifo_full=1 in either state, the state and owner SHALL hold unchanged.
REQ-024: A requester SHALL hold req and req_data stable until gnt; the arbiter does not buffer words.

Reset
REQ-025: With rst=1 at an edge: state becomes ARB, owner becomes NREQ-1 (requester 0 highest priority next), and locked becomes 0.
REQ-026: While rst=1: gnt=0, fifo_wr_en=0, fifo_wdata=0.
REQ-027: Reset asserted in LOCK SHALL abandon the lock, with no further beat granted to the old owner before rearbitration.

Configuration
REQ-028: Macro FIFO_WR_ARB_LOCK_EN: when defined, lock behaviour follows REQ-020 to REQ-022.
REQ-029: When FIFO_WR_ARB_LOCK_EN is undefined:
- req_lock SHALL be ignored.
- The FSM SHALL remain in ARB.
- locked SHALL be constant 0.
- Port list SHALL be unchanged.

Verification
REQ-030: Reset, then req=4'b1111 held and fifo_full=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-031: req=4'b0101 with fifo_full=1 for 3 cycles, then fifo_full=0 -> gnt=0 and fifo_wr_en=0 while full; then gnt=0001, then 0100, with owner unchanged during full.
REQ-032: With LOCK_EN defined, req=4'b0011 and req_lock[0]=1 for 3 beats, dropped on the 4th -> gnt=0001 four times, locked=1 for beats 2-4, then gnt=0010.
REQ-033: In LOCK, owner 0 deasserts req[0] for 2 cycles while req[1]=1 -> gnt=0 for both cycles and locked stays 1.
REQ-034: Assert rst mid-LOCK with owner=2 -> next cycle locked=0, and req=4'b1111 gives gnt=0001.
REQ-035: Without LOCK_EN, repeat REQ-032 stimulus -> gnt alternates 0001,0010 and locked stays 0.
